// File: rtl/matrix_splitter.sv
// matrix_splitter: registered extraction of one BLOCK_SIZE x BLOCK_SIZE block from a
// row-major MATRIX_SIZE x MATRIX_SIZE matrix.
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset, clears block and valid
//   valid_in          capture a block on this edge
//   large_matrix_flat source matrix, element (i,j) at [(i*MATRIX_SIZE+j)*DATA_WIDTH +: DATA_WIDTH]
//   row_block_idx     block row index
//   col_block_idx     block column index
//   block_matrix_flat captured block, element (r,c) at [(r*BLOCK_SIZE+c)*DATA_WIDTH +: DATA_WIDTH]
//   valid_out         registered copy of valid_in
module matrix_splitter #(
  parameter int MATRIX_SIZE = 128,
  parameter int BLOCK_SIZE  = 64,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         valid_in,
  input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] large_matrix_flat,
  input  logic [1:0]                                   row_block_idx,
  input  logic [1:0]                                   col_block_idx,
  output logic [DATA_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0]   block_matrix_flat,
  output logic                                         valid_out
);
  localparam int OW = DATA_WIDTH * BLOCK_SIZE * BLOCK_SIZE;
  logic [OW-1:0] pick;
  logic [OW-1:0] block_d;
  logic [OW-1:0] block_q;
  logic          valid_q;
  // With 2-bit indices each output element can only come from 16 fixed source
  // positions, so every element is a constant-wired 16:1 mux; positions past the
  // matrix edge are tied to zero at elaboration instead of wrapping.
  for (genvar r = 0; r < BLOCK_SIZE; r++) begin : g_row
    for (genvar c = 0; c < BLOCK_SIZE; c++) begin : g_col
      logic [15:0][DATA_WIDTH-1:0] cand;
      for (genvar k = 0; k < 4; k++) begin : g_k
        for (genvar l = 0; l < 4; l++) begin : g_l
          if ((k * BLOCK_SIZE + r < MATRIX_SIZE) && (l * BLOCK_SIZE + c < MATRIX_SIZE)) begin : g_in
            assign cand[k*4+l] = large_matrix_flat[((k*BLOCK_SIZE+r)*MATRIX_SIZE + l*BLOCK_SIZE + c)*DATA_WIDTH +: DATA_WIDTH];
          end else begin : g_out
            assign cand[k*4+l] = '0;
          end
        end
      end
      assign pick[(r*BLOCK_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = cand[{row_block_idx, col_block_idx}];
    end
  end
  always_comb block_d = valid_in ? pick : block_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      valid_q <= 1'b0;
    end else begin
      block_q <= block_d;
      valid_q <= valid_in;
    end
  end
  assign block_matrix_flat = block_q;
  assign valid_out         = valid_q;
endmodule

// File: tb/tb_matrix_splitter.sv
// tb_matrix_splitter: directed self-checking bench for matrix_splitter at default parameters.
module tb_matrix_splitter;
  localparam int MS = 128;
  localparam int BS = 64;
  localparam int DW = 16;
  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     valid_in = 1'b0;
  logic [DW*MS*MS-1:0]      large_matrix_flat;
  logic [1:0]               row_block_idx = 2'd0;
  logic [1:0]               col_block_idx = 2'd0;
  logic [DW*BS*BS-1:0]      block_matrix_flat;
  logic                     valid_out;
  int                       n_vec = 0;
  int                       n_err = 0;
  matrix_splitter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .valid_in          (valid_in),
    .large_matrix_flat (large_matrix_flat),
    .row_block_idx     (row_block_idx),
    .col_block_idx     (col_block_idx),
    .block_matrix_flat (block_matrix_flat),
    .valid_out         (valid_out)
  );
  always #5 clk = ~clk;
  function automatic logic [DW*BS*BS-1:0] exp_block(input int ri, input int ci);
    logic [DW*BS*BS-1:0] e;
    e = '0;
    for (int r = 0; r < BS; r++)
      for (int c = 0; c < BS; c++)
        if (ri * BS + r < MS && ci * BS + c < MS)
          e[(r*BS+c)*DW +: DW] = 16'((ri * BS + r) * 256 + ci * BS + c);
    return e;
  endfunction
  task automatic step(input logic v, input logic [1:0] ri, input logic [1:0] ci);
    valid_in = v;
    row_block_idx = ri;
    col_block_idx = ci;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid got %b want 0", valid_out);
    end
    n_vec++;
    if (block_matrix_flat !== '0) begin
      n_err++;
      $display("FAIL reset_block got nonzero want all zero");
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_back_to_back();
    int exp_c[4][4] = '{'{0, 63, 16128, 16191}, '{64, 127, 16192, 16255},
                        '{16384, 16447, 32512, 32575}, '{16448, 16511, 32576, 32639}};
    int rr;
    int cc;
    logic [DW-1:0] got;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 2'(t >> 1), 2'(t & 1));
      n_vec++;
      if (valid_out !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_valid idx=%0d got %b want 1", t, valid_out);
      end
      for (int k = 0; k < 4; k++) begin
        rr = (k >> 1) * 63;
        cc = (k & 1) * 63;
        got = block_matrix_flat[(rr*BS+cc)*DW +: DW];
        n_vec++;
        if (got !== 16'(exp_c[t][k])) begin
          n_err++;
          $display("FAIL b2b_corner idx=(%0d,%0d) el=[%0d][%0d] got %0d want %0d",
                   t >> 1, t & 1, rr, cc, got, exp_c[t][k]);
        end
      end
      n_vec++;
      if (block_matrix_flat !== exp_block(t >> 1, t & 1)) begin
        n_err++;
        $display("FAIL b2b_full idx=(%0d,%0d) block differs from expected", t >> 1, t & 1);
      end
    end
  endtask
  task automatic test_pulse();
    logic [DW-1:0] got;
    step(1'b1, 2'd1, 2'd1);
    step(1'b0, 2'd0, 2'd0);
    for (int n = 0; n < 2; n++) begin
      got = block_matrix_flat[0 +: DW];
      n_vec++;
      if (valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL pulse_valid cyc=%0d got %b want 0", n, valid_out);
      end
      n_vec++;
      if (got !== 16'd16448) begin
        n_err++;
        $display("FAIL pulse_hold cyc=%0d got %0d want 16448", n, got);
      end
      n_vec++;
      if (block_matrix_flat !== exp_block(1, 1)) begin
        n_err++;
        $display("FAIL pulse_hold_full cyc=%0d block changed while idle", n);
      end
      step(1'b0, 2'd0, 2'd0);
    end
  endtask
  task automatic test_pulse_one_cycle();
    step(1'b1, 2'd1, 2'd1);
    n_vec++;
    if (valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL pulse_rise got %b want 1", valid_out);
    end
  endtask
  task automatic test_out_of_range();
    logic [1:0] idx_r[3] = '{2'd0, 2'd3, 2'd2};
    logic [1:0] idx_c[3] = '{2'd2, 2'd3, 2'd1};
    for (int t = 0; t < 3; t++) begin
      step(1'b1, idx_r[t], idx_c[t]);
      n_vec++;
      if (valid_out !== 1'b1) begin
        n_err++;
        $display("FAIL oor_valid idx=(%0d,%0d) got %b want 1", idx_r[t], idx_c[t], valid_out);
      end
      n_vec++;
      if (block_matrix_flat !== '0) begin
        n_err++;
        $display("FAIL oor_block idx=(%0d,%0d) got nonzero want all zero", idx_r[t], idx_c[t]);
      end
    end
  endtask
  task automatic test_reset_midstream();
    step(1'b1, 2'd0, 2'd1);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_valid got %b want 0", valid_out);
    end
    n_vec++;
    if (block_matrix_flat !== '0) begin
      n_err++;
      $display("FAIL mid_reset_block got nonzero want all zero");
    end
    step(1'b1, 2'd1, 2'd1);
    n_vec++;
    if (valid_out !== 1'b0 || block_matrix_flat !== '0) begin
      n_err++;
      $display("FAIL held_reset valid got %b want 0 or block nonzero", valid_out);
    end
    #2 rst_n = 1'b1;
    step(1'b1, 2'd2, 2'd0);
    n_vec++;
    if (valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_valid got %b want 1", valid_out);
    end
    n_vec++;
    if (block_matrix_flat !== '0) begin
      n_err++;
      $display("FAIL post_reset_block idx=(2,0) got nonzero want all zero");
    end
    step(1'b1, 2'd1, 2'd0);
    n_vec++;
    if (block_matrix_flat !== exp_block(1, 0)) begin
      n_err++;
      $display("FAIL post_reset_full idx=(1,0) block differs from expected");
    end
    step(1'b0, 2'd0, 2'd0);
    n_vec++;
    if (valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL final_valid got %b want 0", valid_out);
    end
  endtask
  initial begin
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++)
        large_matrix_flat[(i*MS+j)*DW +: DW] = 16'(i * 256 + j);
    test_reset();
    test_back_to_back();
    test_pulse();
    test_pulse_one_cycle();
    test_out_of_range();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
